// File: rtl/stack_alu_hs.sv
// rtl/stack_alu_hs.sv - signed N-bit operand stack ALU with valid/ready command port
// One command in flight; MUL runs a radix-2 shift-add over N cycles before the common EXEC step.
module stack_alu_hs #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     opcode,
  input  logic [N-1:0]   input_data,
  output logic           out_valid,
  output logic [N-1:0]   output_data,
  output logic           overflow,
  output logic           stack_err,
  output logic [SPW-1:0] sp,
  output logic           empty,
  output logic           full
);

  localparam int AW = SPW - 1;
  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_DUP  = 3'b001;
  localparam logic [2:0] OP_SWAP = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_EXEC} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [N-1:0]     r_data;
  logic [N-1:0]     r_stack [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic             w_sp_lt2;
  logic             w_mul_last;
  logic             w_err;
  logic             w_exec_ok;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_sec_idx;
  logic [AW-1:0]    w_push_idx;
  logic [N-1:0]     w_a;
  logic [N-1:0]     w_b;
  logic [N-1:0]     w_sum;
  logic [N-1:0]     w_diff;
  logic [N-1:0]     w_res;
  logic             w_ovf;
  logic [SPW-1:0]   w_sp_next;
  logic             w_we1;
  logic [AW-1:0]    w_wi1;
  logic [N-1:0]     w_wd1;
  logic             w_we2;
  logic [AW-1:0]    w_wi2;
  logic [N-1:0]     w_wd2;

  // Index arithmetic wraps modulo DEPTH, so sp==DEPTH still addresses the top at DEPTH-1.
  assign w_top_idx  = r_sp[AW-1:0] - AW'(1);
  assign w_sec_idx  = r_sp[AW-1:0] - AW'(2);
  assign w_push_idx = r_sp[AW-1:0];
  assign w_a        = r_stack[w_top_idx];
  assign w_b        = r_stack[w_sec_idx];
  assign w_sum      = w_b + w_a;
  assign w_diff     = w_b - w_a;

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_sp_lt2   = (r_sp < SPW'(2));
  assign w_accept   = in_valid & in_ready;
  assign w_mul_last = (r_cnt == CW'(N - 1));
  assign w_exec_ok  = (r_state == S_EXEC) & ~w_err;

  assign sp    = r_sp;
  assign empty = w_empty;
  assign full  = w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (opcode == OP_MUL && !w_sp_lt2) ? S_MUL : S_EXEC;
      S_MUL:  if (w_mul_last) w_next = S_EXEC;
      S_EXEC: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  always_comb begin
    w_err = 1'b0;
    case (r_op)
      OP_NOP:  w_err = 1'b0;
      OP_DUP:  w_err = w_empty | w_full;
      OP_PUSH: w_err = w_full;
      OP_POP:  w_err = w_empty;
      default: w_err = w_sp_lt2;
    endcase
  end

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_sp_next = r_sp;
    w_we1     = 1'b0;
    w_wi1     = w_top_idx;
    w_wd1     = w_b;
    w_we2     = 1'b0;
    w_wi2     = w_sec_idx;
    w_wd2     = w_a;
    case (r_op)
      OP_NOP: w_res = w_empty ? '0 : w_a;
      OP_DUP: begin
        w_res     = w_a;
        w_we1     = 1'b1;
        w_wi1     = w_push_idx;
        w_wd1     = w_a;
        w_sp_next = r_sp + SPW'(1);
      end
      OP_SWAP: begin
        w_res = w_b;
        w_we1 = 1'b1;
        w_we2 = 1'b1;
      end
      OP_SUB: begin
        w_res     = w_diff;
        w_ovf     = (w_a[N-1] != w_b[N-1]) && (w_diff[N-1] != w_b[N-1]);
        w_we1     = 1'b1;
        w_wi1     = w_sec_idx;
        w_wd1     = w_diff;
        w_sp_next = r_sp - SPW'(1);
      end
      OP_ADD: begin
        w_res     = w_sum;
        w_ovf     = (w_a[N-1] == w_b[N-1]) && (w_sum[N-1] != w_b[N-1]);
        w_we1     = 1'b1;
        w_wi1     = w_sec_idx;
        w_wd1     = w_sum;
        w_sp_next = r_sp - SPW'(1);
      end
      OP_MUL: begin
        w_res     = r_acc[N-1:0];
        w_ovf     = !((&r_acc[2*N-1:N-1]) || !(|r_acc[2*N-1:N-1]));
        w_we1     = 1'b1;
        w_wi1     = w_sec_idx;
        w_wd1     = r_acc[N-1:0];
        w_sp_next = r_sp - SPW'(1);
      end
      OP_PUSH: begin
        w_res     = r_data;
        w_we1     = 1'b1;
        w_wi1     = w_push_idx;
        w_wd1     = r_data;
        w_sp_next = r_sp + SPW'(1);
      end
      OP_POP: begin
        w_res     = w_a;
        w_sp_next = r_sp - SPW'(1);
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_exec_ok && w_we1) r_stack[w_wi1] <= w_wd1;
    if (w_exec_ok && w_we2) r_stack[w_wi2] <= w_wd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= '0;
      r_op        <= OP_NOP;
      r_data      <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      out_valid   <= 1'b0;
      output_data <= '0;
      overflow    <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_accept) begin
        r_op     <= opcode;
        r_data   <= input_data;
        r_acc    <= '0;
        r_mcand  <= {{N{w_b[N-1]}}, w_b};
        r_mplier <= w_a;
        r_cnt    <= '0;
      end
      // Bit N-1 of the multiplier carries weight -2^(N-1), so its partial product is subtracted.
      if (r_state == S_MUL) begin
        if (r_mplier[0]) r_acc <= w_mul_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (r_state == S_EXEC) begin
        out_valid   <= 1'b1;
        stack_err   <= w_err;
        output_data <= w_err ? '0 : w_res;
        overflow    <= w_err ? 1'b0 : w_ovf;
        if (!w_err) r_sp <= w_sp_next;
      end
    end
  end

endmodule

// File: tb/tb_stack_alu_hs.sv
// tb/tb_stack_alu_hs.sv - randomized and directed bench for stack_alu_hs against a queue-based model
module tb_stack_alu_hs;

  localparam int N     = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] input_data;
  logic        out_valid;
  logic [15:0] output_data;
  logic        overflow;
  logic        stack_err;
  logic [4:0]  sp;
  logic        empty;
  logic        full;

  int n_checks = 0;
  int n_errors = 0;
  int stk[$];

  stack_alu_hs #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input_data(input_data), .out_valid(out_valid),
    .output_data(output_data), .overflow(overflow), .stack_err(stack_err),
    .sp(sp), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int s16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data, input bit hold);
    longint a, b, r;
    logic [15:0] e_out;
    bit e_err, e_ovf, seen, busy_bad;
    int e_lat, n_edges, k, sz;
    sz = stk.size();
    e_out = 16'h0; e_err = 1'b0; e_ovf = 1'b0; e_lat = 1;
    case (op)
      3'd0: e_out = (sz == 0) ? 16'h0 : 16'(stk[sz-1]);
      3'd1: if (sz == 0 || sz == DEPTH) e_err = 1'b1;
            else begin e_out = 16'(stk[sz-1]); stk.push_back(stk[sz-1]); end
      3'd2: if (sz < 2) e_err = 1'b1;
            else begin
              a = stk.pop_back(); b = stk.pop_back();
              stk.push_back(int'(a)); stk.push_back(int'(b)); e_out = 16'(b);
            end
      3'd3, 3'd4, 3'd5:
            if (sz < 2) e_err = 1'b1;
            else begin
              a = stk.pop_back(); b = stk.pop_back();
              r = (op == 3'd3) ? b - a : (op == 3'd4) ? b + a : b * a;
              e_ovf = (r > 32767) || (r < -32768);
              stk.push_back(s16(r)); e_out = 16'(r);
              if (op == 3'd5) e_lat = N + 1;
            end
      3'd6: if (sz == DEPTH) e_err = 1'b1;
            else begin stk.push_back(s16(longint'(data))); e_out = data; end
      default: if (sz == 0) e_err = 1'b1;
               else e_out = 16'(stk.pop_back());
    endcase

    @(negedge clk);
    in_valid = 1'b1; opcode = op; input_data = data;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    if (!hold) begin in_valid = 1'b0; opcode = 3'($urandom); input_data = 16'($urandom); end
    n_edges = 0; seen = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); n_edges++;
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      if (in_ready) busy_bad = 1'b1;
    end
    in_valid = 1'b0;
    check("done", 32'(seen), 32'd1);
    check("latency", n_edges, e_lat);
    check("busy_not_ready", 32'(busy_bad), 32'd0);
    check("output_data", 32'(output_data), 32'(e_out));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("stack_err", 32'(stack_err), 32'(e_err));
    check("sp", 32'(sp), stk.size());
    check("empty", 32'(empty), 32'(stk.size() == 0));
    check("full", 32'(full), 32'(stk.size() == DEPTH));
    @(negedge clk);
    check("single_pulse", 32'(out_valid), 32'd0);
  endtask

  task automatic drain();
    while (stk.size() > 0) do_cmd(3'd7, 16'h0, 1'b0);
  endtask

  initial begin
    bit stray;
    rst = 1'b1; in_valid = 1'b0; opcode = 3'd0; input_data = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_output_data", 32'(output_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_stack_err", 32'(stack_err), 32'd0);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    do_cmd(3'd6, 16'd10, 1'b0);
    do_cmd(3'd6, 16'hFC18, 1'b0);
    do_cmd(3'd4, 16'h0, 1'b0);
    check("s1_add_value", 32'(output_data), 32'h0000FC22);
    do_cmd(3'd6, 16'd100, 1'b0);
    do_cmd(3'd5, 16'h0, 1'b0);
    check("s2_mul_value", 32'(output_data), 32'd32072);
    check("s2_mul_ovf", 32'(overflow), 32'd1);

    do_cmd(3'd6, 16'h7FFF, 1'b0);
    do_cmd(3'd6, 16'd1, 1'b0);
    do_cmd(3'd4, 16'h0, 1'b0);
    check("s3_add_wrap", 32'(output_data), 32'h00008000);
    do_cmd(3'd6, 16'h8000, 1'b0);
    do_cmd(3'd6, 16'd1, 1'b0);
    do_cmd(3'd3, 16'h0, 1'b0);
    check("s3_sub_wrap", 32'(output_data), 32'h00007FFF);

    drain();
    do_cmd(3'd7, 16'h0, 1'b0);
    do_cmd(3'd1, 16'h0, 1'b0);
    do_cmd(3'd0, 16'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_cmd(3'd6, 16'($urandom), 1'b0);
    do_cmd(3'd6, 16'h1234, 1'b0);
    do_cmd(3'd1, 16'h0, 1'b0);
    drain();
    do_cmd(3'd6, 16'd5, 1'b0);
    do_cmd(3'd4, 16'h0, 1'b0);
    do_cmd(3'd5, 16'h0, 1'b0);
    do_cmd(3'd2, 16'h0, 1'b0);
    drain();

    do_cmd(3'd6, 16'd3, 1'b0);
    do_cmd(3'd6, 16'd7, 1'b0);
    do_cmd(3'd2, 16'h0, 1'b0);
    do_cmd(3'd1, 16'h0, 1'b1);
    do_cmd(3'd7, 16'h0, 1'b0);
    do_cmd(3'd7, 16'h0, 1'b0);
    do_cmd(3'd7, 16'h0, 1'b0);
    check("s5_last_pop", 32'(output_data), 32'd7);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
      do_cmd(op, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    drain();
    do_cmd(3'd6, 16'd1234, 1'b0);
    do_cmd(3'd6, 16'hFF85, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; opcode = 3'd5; input_data = 16'h0;
    @(posedge clk); #1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_sp", 32'(sp), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_empty", 32'(empty), 32'd1);
    stk.delete();
    stray = 1'b0;
    repeat (25) begin @(negedge clk); if (out_valid) stray = 1'b1; end
    check("abort_no_pulse", 32'(stray), 32'd0);
    do_cmd(3'd6, 16'd9, 1'b1);
    do_cmd(3'd6, 16'hFFFD, 1'b1);
    do_cmd(3'd5, 16'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
